load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32: number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1: reset is synchronous and active-high.
REQ-004 SHALL have port req_valid  in  1: CPU request present.
REQ-005 SHALL have port req_ready  out  1: unit accepts a request this cycle.
REQ-006 SHALL have port req_we  in  1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 SHALL have port req_unsigned  in  1: zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  in  32: byte address.
REQ-010 SHALL have port req_wdata  in  32: store data, right-aligned.
REQ-011 SHALL have port resp_valid  out  1: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32: extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1: error flag, qualified by resp_valid.
REQ-014 SHALL have ports mem_wr_en, mem_rd_en (out 1) and mem_addr, mem_wdata (out 32): memory-side drive.
REQ-015 SHALL have port mem_rdata  in  32: memory read data, combinational, valid in the same cycle as mem_rd_en.

Function
REQ-016 SHALL implement FSM states IDLE, RD, RMW_RD, WR, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL accept a request on req_valid && req_ready, latching all req_* fields; req_valid outside IDLE is ignored.
REQ-018 SHALL, from IDLE on accept, go to RESP (error) if the request is illegal, to RD for loads, to WR for word stores, and to RMW_RD for byte or half stores.
REQ-019 SHALL treat as illegal: req_size=11, or word index req_addr[31:2] >= MEM_WORDS; illegal requests make no memory access.
REQ-020 SHALL drive mem_addr = {2'b00, latched req_addr[31:2]} (word index) in RD, RMW_RD and WR, and 0 elsewhere.
REQ-021 SHALL assert mem_rd_en only in RD/RMW_RD and mem_wr_en only in WR, decoded from registered state.
REQ-022 SHALL, in RD, select the lane from mem_rdata (little-endian: byte at bits [8*a[1:0]+7 : 8*a[1:0]], half at a[1]), extend it, and register the result for resp_rdata.
REQ-023 SHALL, in RMW_RD, register mem_rdata and then, in WR, write that word with only the addressed byte or half lanes replaced from req_wdata low bits.
REQ-024 SHALL hold the RESP state for exactly one cycle with resp_valid=1, then return to IDLE.
REQ-025 SHALL have a latency from accept at cycle N to resp_valid of N+2 for loads and word stores, N+3 for sub-word stores, and N+1 for errors.
REQ-026 SHALL return to IDLE after RESP, so a back-to-back request is accepted the cycle after resp_valid.
REQ-027 SHALL not perform any write-protection of word 0; the memory itself discards writes to word 0, and a load of word 0 returns 0.

Reset
REQ-028 SHALL, on a clk edge with reset=1, enter IDLE and clear all registers; resp_valid, resp_err, resp_rdata and all mem_* outputs read 0, and req_ready reads 1.
REQ-029 SHALL abandon any in-flight transaction on reset without issuing a response; reset has priority over every transition.

Configuration
REQ-030 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat a half access with a[0]=1 or a word access with a[1:0]!=0 as illegal (error response, no access).
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, force the offending low address bits to 0 (aligning the access down) and raise no error.

Verification
REQ-032 SHALL be verified by: store word 0xDEADBEEF to 0x08, then load word from 0x08 -> resp_rdata=0xDEADBEEF, resp_valid at N+2 for each access.
REQ-033 SHALL be verified by: with word 2=0xDEADBEEF, store byte 0x55 to 0x09 -> mem_wdata=0xDEAD55EF in WR, resp_valid at N+3.
REQ-034 SHALL be verified by: load signed byte from 0x0B holding 0xDE -> resp_rdata=0xFFFFFFDE; the unsigned load returns 0x000000DE.
REQ-035 SHALL be verified by: load word from 0x80 with MEM_WORDS=32 -> resp_err=1 at N+1, mem_rd_en never asserted.
REQ-036 SHALL be verified by: load half from 0x0A with word 2=0x8001xxxx -> resp_rdata=0xFFFF8001; a half load from 0x05 gives resp_err=1 with LSU_MISALIGN_TRAP_EN and data from 0x04 without it.
REQ-037 SHALL be verified by: asserting reset during WR of a sub-word store -> next cycle IDLE, req_ready=1, no resp_valid pulse.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side signal bundle for load_store_unit.
//   slave  : the load/store unit's view (drives req_ready, resp_*, mem_* drive;
//            samples req_* and mem_rdata).
//   master : the CPU plus data-memory environment's view (the reverse).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_wr_en, mem_rd_en, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_wr_en, mem_rd_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU byte/half/word load or store at a time and
// runs it against a word-addressed data memory of MEM_WORDS 32-bit words.
// Sub-word stores are done as read-modify-write. Illegal requests (size 11 or
// word index out of range) return an error response without touching memory.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high
//   bus    - load_store_unit_if.slave: req_* handshake, resp_* completion,
//            mem_* memory drive, mem_rdata combinational read data
// Build option: define LSU_MISALIGN_TRAP_EN to make misaligned half/word
// accesses illegal; otherwise they are aligned down silently.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      r_state, w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_illegal;
  logic [31:0] w_addr_al;
  logic [31:0] w_lane;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  assign w_accept = (r_state == IDLE) && bus.req_valid;

  // Legality and address alignment are resolved at accept time so the latched
  // address is already the one used for the access.
  always_comb begin
    w_addr_al = bus.req_addr;
    w_illegal = (bus.req_size == 2'b11) ||
                ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
        (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00))
      w_illegal = 1'b1;
`else
    if (bus.req_size == 2'b01) w_addr_al[0]   = 1'b0;
    if (bus.req_size == 2'b10) w_addr_al[1:0] = 2'b00;
`endif
  end

  // Load lane select: shift the addressed byte/half down to bit 0, then extend.
  always_comb begin
    w_lane = bus.mem_rdata >> {r_addr[1:0], 3'b000};
    case (r_size)
      2'b00:   w_load_ext = r_uns ? {24'h0, w_lane[7:0]}
                                  : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load_ext = r_uns ? {16'h0, w_lane[15:0]}
                                  : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load_ext = bus.mem_rdata;
    endcase
  end

  // Store merge: replace only the addressed lanes of the word read in RMW_RD.
  always_comb begin
    w_merged = r_word;
    case (r_size)
      2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
      2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
      default: w_merged = r_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 1'b0;
    bus.mem_rd_en  = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_illegal)                 w_next = RESP;
          else if (!bus.req_we)          w_next = RD;
          else if (bus.req_size == 2'b10) w_next = WR;
          else                           w_next = RMW_RD;
        end
      end
      RD: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = {2'b00, r_addr[31:2]};
        w_next        = RESP;
      end
      RMW_RD: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = {2'b00, r_addr[31:2]};
        w_next        = WR;
      end
      WR: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = {2'b00, r_addr[31:2]};
        bus.mem_wdata = w_merged;
        w_next        = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_err;
        bus.resp_rdata = r_rdata;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_size  <= bus.req_size;
        r_uns   <= bus.req_unsigned;
        r_addr  <= w_addr_al;
        r_wdata <= bus.req_wdata;
        r_rdata <= '0;
        r_err   <= w_illegal;
      end
      if (r_state == RD)     r_rdata <= w_load_ext;
      if (r_state == RMW_RD) r_word  <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory: 32 words, word 0 reads as 0 and discards writes.
  logic [31:0] mem [0:31];
  assign bus.mem_rdata = (bus.mem_rd_en && bus.mem_addr < 32 && bus.mem_addr != 0)
                         ? mem[bus.mem_addr[4:0]] : 32'h0;
  always @(posedge clk)
    if (bus.mem_wr_en && bus.mem_addr < 32 && bus.mem_addr != 0)
      mem[bus.mem_addr[4:0]] <= bus.mem_wdata;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_lat;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sv(input int i, input logic we, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                    input logic err, input int unsigned lat, input logic [31:0] wd);
    vecs[i].we = we; vecs[i].size = size; vecs[i].uns = uns; vecs[i].addr = addr;
    vecs[i].wdata = wdata; vecs[i].exp_rdata = rdata; vecs[i].exp_err = err;
    vecs[i].exp_lat = lat; vecs[i].exp_wd = wd;
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int unsigned lat;
    logic [31:0] rdat, wd, maddr;
    logic err, rd_seen, wr_seen;
    lat = 0; rdat = '0; wd = '0; maddr = '0; err = 1'b0; rd_seen = 1'b0; wr_seen = 1'b0;
    @(negedge clk);
    check32({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
    bus.req_we = v.we; bus.req_size = v.size; bus.req_unsigned = v.uns;
    bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin rd_seen = 1'b1; maddr = bus.mem_addr; end
      if (bus.mem_wr_en) begin wr_seen = 1'b1; wd = bus.mem_wdata; maddr = bus.mem_addr; end
      if (bus.resp_valid) begin
        lat = k; rdat = bus.resp_rdata; err = bus.resp_err;
        break;
      end
    end
    check32({tag, "_lat"}, lat, v.exp_lat);
    check32({tag, "_rdata"}, rdat, v.exp_rdata);
    check32({tag, "_err"}, {31'h0, err}, {31'h0, v.exp_err});
    if (v.exp_err) begin
      check32({tag, "_noaccess"}, {30'h0, rd_seen, wr_seen}, 32'h0);
    end else begin
      check32({tag, "_access"}, {30'h0, rd_seen, wr_seen},
              {30'h0, (!v.we || v.size != 2'b10), v.we});
      check32({tag, "_maddr"}, maddr, {2'b00, v.addr[31:2]});
      if (v.we) check32({tag, "_wdata"}, wd, v.exp_wd);
    end
  endtask

  initial begin
    vec_t post;
    int   pulses;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;

    sv(0,  1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0,        0, 2, 32'hDEADBEEF);
    sv(1,  0, 2'b10, 0, 32'h08, 32'h0,        32'hDEADBEEF, 0, 2, 32'h0);
    sv(2,  1, 2'b00, 0, 32'h09, 32'hAAAAAA55, 32'h0,        0, 3, 32'hDEAD55EF);
    sv(3,  0, 2'b10, 0, 32'h08, 32'h0,        32'hDEAD55EF, 0, 2, 32'h0);
    sv(4,  0, 2'b00, 0, 32'h0B, 32'h0,        32'hFFFFFFDE, 0, 2, 32'h0);
    sv(5,  0, 2'b00, 1, 32'h0B, 32'h0,        32'h000000DE, 0, 2, 32'h0);
    sv(6,  0, 2'b00, 0, 32'h09, 32'h0,        32'h00000055, 0, 2, 32'h0);
    sv(7,  0, 2'b10, 0, 32'h80, 32'h0,        32'h0,        1, 1, 32'h0);
    sv(8,  1, 2'b01, 0, 32'h0A, 32'hFFFF8001, 32'h0,        0, 3, 32'h800155EF);
    sv(9,  0, 2'b01, 0, 32'h0A, 32'h0,        32'hFFFF8001, 0, 2, 32'h0);
    sv(10, 0, 2'b01, 1, 32'h0A, 32'h0,        32'h00008001, 0, 2, 32'h0);
    sv(11, 0, 2'b01, 0, 32'h08, 32'h0,        32'h000055EF, 0, 2, 32'h0);
    sv(12, 1, 2'b10, 0, 32'h04, 32'h11223344, 32'h0,        0, 2, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    sv(13, 0, 2'b01, 0, 32'h05, 32'h0,        32'h0,        1, 1, 32'h0);
    sv(14, 0, 2'b10, 0, 32'h07, 32'h0,        32'h0,        1, 1, 32'h0);
`else
    sv(13, 0, 2'b01, 0, 32'h05, 32'h0,        32'h00003344, 0, 2, 32'h0);
    sv(14, 0, 2'b10, 0, 32'h07, 32'h0,        32'h11223344, 0, 2, 32'h0);
`endif
    sv(15, 0, 2'b11, 0, 32'h08, 32'h0,        32'h0,        1, 1, 32'h0);
    sv(16, 1, 2'b10, 0, 32'h7C, 32'hCAFEF00D, 32'h0,        0, 2, 32'hCAFEF00D);
    sv(17, 0, 2'b10, 0, 32'h7C, 32'h0,        32'hCAFEF00D, 0, 2, 32'h0);
    sv(18, 1, 2'b10, 0, 32'h00, 32'hFFFFFFFF, 32'h0,        0, 2, 32'hFFFFFFFF);
    sv(19, 0, 2'b10, 0, 32'h00, 32'h0,        32'h0,        0, 2, 32'h0);
    sv(20, 1, 2'b00, 0, 32'h80, 32'h000000AA, 32'h0,        1, 1, 32'h0);
    sv(21, 0, 2'b00, 1, 32'h7E, 32'h0,        32'h000000FE, 0, 2, 32'h0);
    sv(22, 1, 2'b01, 0, 32'h7E, 32'h0000BEEF, 32'h0,        0, 3, 32'hBEEFF00D);

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check32("rst_resp", {29'h0, bus.resp_valid, bus.resp_err, bus.mem_rd_en}, 32'h0);
    check32("rst_wr_en", {31'h0, bus.mem_wr_en}, 32'h0);
    check32("rst_rdata", bus.resp_rdata, 32'h0);
    check32("rst_maddr", bus.mem_addr, 32'h0);
    check32("rst_mwdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) do_txn(vecs[i], $sformatf("v%0d", i));

    // Reset in the WR cycle of a sub-word store: abandoned, no response.
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h5A; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check32("rmw_rd_en", {31'h0, bus.mem_rd_en}, 32'h1);
    @(negedge clk);
    check32("rmw_wr_en", {31'h0, bus.mem_wr_en}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check32("abort_ready", {31'h0, bus.req_ready}, 32'h1);
    check32("abort_outs", {29'h0, bus.resp_valid, bus.mem_wr_en, bus.mem_rd_en}, 32'h0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) pulses++;
    end
    check32("abort_nopulse", pulses, 32'h0);

    post = vecs[17];
    post.exp_rdata = 32'hBEEFF00D;
    do_txn(post, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
